pos_error_tracker: RTL and testbench
====================================

POS_ERROR_TRACKER -- requirements
Module: pos_error_tracker

Interface
REQ-001 SHALL provide parameter POS_W, default 12, position/target width in bits.
REQ-002 SHALL provide parameter CH, default 2, number of independent motor channels (1..8).
REQ-003 SHALL provide parameter TOL, default 2, in-position tolerance on |error|.
REQ-004 SHALL provide parameter SETTLE_CNT, default 1024, consecutive in-tolerance samples required for in_pos.
REQ-005 SHALL provide parameter STEP_MAX, default 4, maximum setpoint change per ramp tick.
REQ-006 SHALL provide parameter RAMP_DIV, default 480, clocks per ramp tick (>=1).
REQ-007 SHALL provide ports: clk_48  in  1  sole clock, rising edge.
REQ-008 SHALL provide ports: reset  in  1  asynchronous, active-high reset.
REQ-009 SHALL provide ports: cmd_valid  in  1; cmd_ready  out  1; cmd_ch  in  3  target channel; cmd_target  in  POS_W  unsigned target.
REQ-010 SHALL provide ports: pos_valid  in  1; pos  in  CH*POS_W  packed unsigned positions, channel 0 in LSBs.
REQ-011 SHALL provide ports: error  out  CH*(POS_W+1)  signed setpoint-minus-position; errorabs  out  CH*POS_W; errorsign  out  CH  (1 = negative).
REQ-012 SHALL provide ports: err_valid  out  1; in_pos  out  CH; cmd_err  out  1  one-cycle pulse on invalid channel.

Function
REQ-013 A command SHALL transfer on a rising edge where cmd_valid and cmd_ready are both 1; the target register of cmd_ch SHALL load cmd_target on that edge.
REQ-014 cmd_ready SHALL be 0 while the channel addressed by cmd_ch has setpoint != target (ramp active), and 1 otherwise.
REQ-015 For cmd_ch >= CH, cmd_ready SHALL be 1, no state SHALL change, and cmd_err SHALL pulse high for the following cycle.
REQ-016 A divider counter SHALL count 0..RAMP_DIV-1 and wrap; a ramp tick SHALL occur on the wrap cycle.
REQ-017 On each ramp tick, every channel's setpoint SHALL move toward its target by min(STEP_MAX, |target-setpoint|), never overshooting.
REQ-018 pos SHALL be captured into per-channel registers on the edge where pos_valid=1.
REQ-019 On the next edge, error[ch] SHALL equal setpoint[ch] minus the captured pos[ch], computed in POS_W+1-bit signed arithmetic with no overflow or saturation; err_valid SHALL be 1 for exactly that cycle.
REQ-020 errorsign[ch] SHALL equal error[ch] MSB; errorabs[ch] SHALL equal |error[ch]| (max 2^POS_W-1 fits in POS_W bits).
REQ-021 error, errorabs and errorsign SHALL hold their values between samples.
REQ-022 Per channel, the settle counter SHALL increment on each sample with errorabs <= TOL and setpoint == target, saturating at SETTLE_CNT.
REQ-023 The settle counter SHALL clear on any sample with errorabs > TOL or on command acceptance for that channel; clear SHALL take priority over increment in the same cycle.
REQ-024 in_pos[ch] SHALL be 1 iff the settle counter equals SETTLE_CNT.
REQ-025 A sample coincident with command acceptance or ramp tick SHALL use the setpoint value before that edge's update.
REQ-026 Back-to-back pos_valid SHALL produce one err_valid per sample at 1-cycle latency, with no loss.

Reset
REQ-027 While reset=1: targets, setpoints, captured positions, error, errorabs, errorsign, settle counters, divider, in_pos, err_valid and cmd_err SHALL be 0, and cmd_ready SHALL be 1.
REQ-028 Reset asserted mid-ramp or mid-settle SHALL abandon the operation; no command SHALL be retained after release.

Configuration
REQ-029 Macro POS_ERR_SLEW_LIMIT_EN defined: ramping per REQ-014, REQ-016 and REQ-017 is active.
REQ-030 Macro POS_ERR_SLEW_LIMIT_EN undefined: setpoint SHALL equal target one edge after acceptance, cmd_ready SHALL be 1 for valid channels, and the divider SHALL be absent; STEP_MAX and RAMP_DIV are ignored.

Verification
REQ-031 Reset, then pos ch0=100, pos_valid=1 for 1 cycle -> next cycle err_valid=1, error ch0=-100, errorabs=100, errorsign=1.
REQ-032 POS_ERR_SLEW_LIMIT_EN, STEP_MAX=4, RAMP_DIV=2, cmd ch0 target=10 -> setpoint 4,8,10 on successive ticks; cmd_ready for ch0 low until setpoint=10.
REQ-033 Target=174, pos held at 173, TOL=2, SETTLE_CNT=4, pos_valid every cycle -> in_pos[0] rises after 4th sample; then pos=170 -> in_pos[0]=0 the next cycle.
REQ-034 cmd_ch=5 with CH=2 -> cmd_err pulses once; targets and in_pos unchanged.
REQ-035 Reset asserted mid-ramp -> all outputs 0, cmd_ready=1 immediately, asynchronously to clk_48.

Source files
------------

// File: rtl/pos_error_tracker.sv
// Per-channel position error tracker: setpoint-minus-position error, |error|, sign and settle detect.
// Define POS_ERR_SLEW_LIMIT_EN to ramp setpoints toward targets at STEP_MAX per RAMP_DIV clocks.
module pos_error_tracker #(
  parameter int POS_W      = 12,
  parameter int CH         = 2,
  parameter int TOL        = 2,
  parameter int SETTLE_CNT = 1024,
  parameter int STEP_MAX   = 4,
  parameter int RAMP_DIV   = 480
) (
  input  logic                    clk_48,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_ch,
  input  logic [POS_W-1:0]        cmd_target,
  input  logic                    pos_valid,
  input  logic [CH*POS_W-1:0]     pos,
  output logic [CH*(POS_W+1)-1:0] error,
  output logic [CH*POS_W-1:0]     errorabs,
  output logic [CH-1:0]           errorsign,
  output logic                    err_valid,
  output logic [CH-1:0]           in_pos,
  output logic                    cmd_err
);

  localparam int SW = $clog2(SETTLE_CNT + 1);
  localparam logic [POS_W-1:0] TOL_V    = POS_W'(TOL);
  localparam logic [SW-1:0]    SETTLE_V = SW'(SETTLE_CNT);

  if (CH < 1 || CH > 8 || SETTLE_CNT < 1 || STEP_MAX < 1 || RAMP_DIV < 1) begin : gParamCheck
    $error("pos_error_tracker: illegal parameter value");
  end

  logic [POS_W-1:0]        target_q   [CH];
  logic [POS_W-1:0]        setpoint_q [CH];
  logic [POS_W-1:0]        setpoint_d [CH];
  logic [POS_W-1:0]        posCap_q   [CH];
  logic signed [POS_W:0]   error_q    [CH];
  logic signed [POS_W:0]   error_d    [CH];
  logic signed [POS_W:0]   negErr     [CH];
  logic [POS_W-1:0]        errAbs_q   [CH];
  logic [POS_W-1:0]        errAbs_d   [CH];
  logic [SW-1:0]           settle_q   [CH];
  logic [SW-1:0]           settle_d   [CH];
  logic [CH-1:0]           accept;
  logic                    chOk;
  logic                    sample_q;
  logic                    errValid_q;
  logic                    cmdErr_q;

`ifdef POS_ERR_SLEW_LIMIT_EN
  localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [POS_W-1:0] STEP_V = POS_W'(STEP_MAX);
  logic [DW-1:0]    div_q;
  logic [DW-1:0]    div_d;
  logic             tick;
  logic [POS_W-1:0] gap     [CH];
  logic [POS_W-1:0] stepAmt [CH];
`endif

  assign chOk = (int'(cmd_ch) < CH);

  // A channel refuses new commands only while its setpoint is still ramping.
  always_comb begin
    cmd_ready = 1'b1;
    accept    = '0;
    for (int c = 0; c < CH; c++) begin
`ifdef POS_ERR_SLEW_LIMIT_EN
      if (cmd_ch == 3'(c) && setpoint_q[c] != target_q[c]) cmd_ready = 1'b0;
`endif
    end
    for (int c = 0; c < CH; c++) accept[c] = cmd_valid && cmd_ready && (cmd_ch == 3'(c));
  end

`ifdef POS_ERR_SLEW_LIMIT_EN
  assign tick  = (div_q == DW'(RAMP_DIV - 1));
  assign div_d = tick ? '0 : div_q + DW'(1);
`endif

  // Error, settle and setpoint next-state; everything reads pre-edge setpoints.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      error_d[c]  = $signed({1'b0, setpoint_q[c]}) - $signed({1'b0, posCap_q[c]});
      negErr[c]   = -error_d[c];
      errAbs_d[c] = error_d[c][POS_W] ? negErr[c][POS_W-1:0] : error_d[c][POS_W-1:0];

      settle_d[c] = settle_q[c];
      if (accept[c] || (sample_q && errAbs_d[c] > TOL_V))
        settle_d[c] = '0;
      else if (sample_q && setpoint_q[c] == target_q[c] && settle_q[c] != SETTLE_V)
        settle_d[c] = settle_q[c] + SW'(1);

`ifdef POS_ERR_SLEW_LIMIT_EN
      gap[c]        = (target_q[c] >= setpoint_q[c]) ? target_q[c] - setpoint_q[c]
                                                     : setpoint_q[c] - target_q[c];
      stepAmt[c]    = (gap[c] > STEP_V) ? STEP_V : gap[c];
      setpoint_d[c] = setpoint_q[c];
      if (tick) begin
        if (target_q[c] > setpoint_q[c]) setpoint_d[c] = setpoint_q[c] + stepAmt[c];
        else                             setpoint_d[c] = setpoint_q[c] - stepAmt[c];
      end
`else
      setpoint_d[c] = target_q[c];
`endif
    end
  end

  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      sample_q   <= 1'b0;
      errValid_q <= 1'b0;
      cmdErr_q   <= 1'b0;
`ifdef POS_ERR_SLEW_LIMIT_EN
      div_q      <= '0;
`endif
      for (int c = 0; c < CH; c++) begin
        target_q[c]   <= '0;
        setpoint_q[c] <= '0;
        posCap_q[c]   <= '0;
        error_q[c]    <= '0;
        errAbs_q[c]   <= '0;
        settle_q[c]   <= '0;
      end
    end else begin
      sample_q   <= pos_valid;
      errValid_q <= sample_q;
      cmdErr_q   <= cmd_valid && !chOk;
`ifdef POS_ERR_SLEW_LIMIT_EN
      div_q      <= div_d;
`endif
      for (int c = 0; c < CH; c++) begin
        if (pos_valid) posCap_q[c] <= pos[c*POS_W +: POS_W];
        if (sample_q) begin
          error_q[c]  <= error_d[c];
          errAbs_q[c] <= errAbs_d[c];
        end
        settle_q[c]   <= settle_d[c];
        setpoint_q[c] <= setpoint_d[c];
        if (accept[c]) target_q[c] <= cmd_target;
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : gOut
    assign error[c*(POS_W+1) +: POS_W+1] = error_q[c];
    assign errorabs[c*POS_W +: POS_W]    = errAbs_q[c];
    assign errorsign[c]                  = error_q[c][POS_W];
    assign in_pos[c]                     = (settle_q[c] == SETTLE_V);
  end

  assign err_valid = errValid_q;
  assign cmd_err   = cmdErr_q;

endmodule

// File: tb/tb_pos_error_tracker.sv
// Self-checking bench for pos_error_tracker: directed vector table, corner sequences and
// randomized traffic against a behavioural model (honours POS_ERR_SLEW_LIMIT_EN).
module tb_pos_error_tracker;

  localparam int POS_W      = 12;
  localparam int CH         = 2;
  localparam int TOL        = 2;
  localparam int SETTLE_CNT = 4;
  localparam int STEP_MAX   = 4;
  localparam int RAMP_DIV   = 2;
  localparam int EW         = POS_W + 1;
`ifdef POS_ERR_SLEW_LIMIT_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic                clk_48;
  logic                reset;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          cmd_ch;
  logic [POS_W-1:0]    cmd_target;
  logic                pos_valid;
  logic [CH*POS_W-1:0] pos;
  logic [CH*EW-1:0]    error;
  logic [CH*POS_W-1:0] errorabs;
  logic [CH-1:0]       errorsign;
  logic                err_valid;
  logic [CH-1:0]       in_pos;
  logic                cmd_err;

  pos_error_tracker #(
    .POS_W(POS_W), .CH(CH), .TOL(TOL), .SETTLE_CNT(SETTLE_CNT),
    .STEP_MAX(STEP_MAX), .RAMP_DIV(RAMP_DIV)
  ) dut (
    .clk_48(clk_48), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_target(cmd_target), .pos_valid(pos_valid), .pos(pos),
    .error(error), .errorabs(errorabs), .errorsign(errorsign), .err_valid(err_valid),
    .in_pos(in_pos), .cmd_err(cmd_err)
  );

  initial clk_48 = 1'b0;
  always #5 clk_48 = ~clk_48;

  int checks;
  int failures;

  // Reference model state in plain integers.
  int mTgt[CH];
  int mSp[CH];
  int mCap[CH];
  int mErr[CH];
  int mSettle[CH];
  int mDiv;
  bit mPend, mEv, mCe;

  typedef struct {
    bit       cv;
    bit [2:0] cch;
    int       ctg;
    bit       pv;
    int       p0;
    int       p1;
    bit       xEv;
    int       xErr0;
    bit       xCe;
  } vec_t;

  vec_t tbl[6];

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < CH; c++) begin
      mTgt[c] = 0; mSp[c] = 0; mCap[c] = 0; mErr[c] = 0; mSettle[c] = 0;
    end
    mDiv = 0; mPend = 0; mEv = 0; mCe = 0;
  endtask

  function automatic bit modelReady();
    int idx;
    idx = int'(cmd_ch);
    if (idx >= CH || !SLEW) return 1'b1;
    return mSp[idx] == mTgt[idx];
  endfunction

  // Advance the model by one clock using the inputs presented now, then clock the DUT.
  task automatic applyStimulus();
    bit acc, tick;
    int ch, e, a, gap, stp;
    if (reset) modelReset();
    else begin
      ch   = int'(cmd_ch);
      acc  = cmd_valid && modelReady() && (ch < CH);
      tick = SLEW && (mDiv == RAMP_DIV - 1);
      for (int c = 0; c < CH; c++) begin
        e = mSp[c] - mCap[c];
        a = (e < 0) ? -e : e;
        if ((acc && ch == c) || (mPend && a > TOL)) mSettle[c] = 0;
        else if (mPend && mSp[c] == mTgt[c] && mSettle[c] < SETTLE_CNT) mSettle[c]++;
        if (mPend) mErr[c] = e;
        if (SLEW) begin
          if (tick) begin
            gap = mTgt[c] - mSp[c];
            stp = ((gap < 0) ? -gap : gap);
            if (stp > STEP_MAX) stp = STEP_MAX;
            mSp[c] = mSp[c] + ((gap > 0) ? stp : -stp);
          end
        end else mSp[c] = mTgt[c];
        if (acc && ch == c) mTgt[c] = int'(cmd_target);
        if (pos_valid) mCap[c] = int'(pos[c*POS_W +: POS_W]);
      end
      mDiv  = tick ? 0 : mDiv + 1;
      mEv   = mPend;
      mPend = pos_valid;
      mCe   = cmd_valid && (ch >= CH);
    end
    @(posedge clk_48);
    #1;
  endtask

  task automatic checkOutput();
    int e;
    checkVal("cmd_ready", int'(cmd_ready), int'(modelReady()));
    checkVal("err_valid", int'(err_valid), int'(mEv));
    checkVal("cmd_err", int'(cmd_err), int'(mCe));
    for (int c = 0; c < CH; c++) begin
      e = mErr[c];
      checkVal($sformatf("error[%0d]", c), int'($signed(error[c*EW +: EW])), e);
      checkVal($sformatf("errorabs[%0d]", c), int'(errorabs[c*POS_W +: POS_W]), (e < 0) ? -e : e);
      checkVal($sformatf("errorsign[%0d]", c), int'(errorsign[c]), int'(e < 0));
      checkVal($sformatf("in_pos[%0d]", c), int'(in_pos[c]), int'(mSettle[c] == SETTLE_CNT));
    end
  endtask

  task automatic step();
    applyStimulus();
    checkOutput();
  endtask

  task automatic setPos(input int p0, input int p1);
    pos[0 +: POS_W]     = POS_W'(p0);
    pos[POS_W +: POS_W] = POS_W'(p1);
  endtask

  initial begin
    int n, lastErr, cur, base, pv;
    bit seen;
    int seq[$];

    checks = 0; failures = 0;
    cmd_valid = 0; cmd_ch = 0; cmd_target = 0; pos_valid = 0; pos = '0;
    reset = 1'b1;
    modelReset();
    repeat (2) @(posedge clk_48);
    #1;
    checkOutput();
    reset = 1'b0;
    repeat (2) step();

    // Directed vectors: {cv, cch, ctg, pv, p0, p1, expected err_valid, error ch0, cmd_err}.
    tbl[0] = '{1'b0, 3'd0, 0,  1'b1, 100, 0, 1'b0, 0,    1'b0};
    tbl[1] = '{1'b0, 3'd0, 0,  1'b0, 0,   0, 1'b1, -100, 1'b0};
    tbl[2] = '{1'b1, 3'd5, 77, 1'b0, 0,   0, 1'b0, -100, 1'b1};
    tbl[3] = '{1'b0, 3'd0, 0,  1'b0, 0,   0, 1'b0, -100, 1'b0};
    tbl[4] = '{1'b1, 3'd1, 50, 1'b1, 20,  7, 1'b0, -100, 1'b0};
    tbl[5] = '{1'b0, 3'd0, 0,  1'b0, 0,   0, 1'b1, -20,  1'b0};
    for (int i = 0; i < 6; i++) begin
      cmd_valid = tbl[i].cv; cmd_ch = tbl[i].cch; cmd_target = POS_W'(tbl[i].ctg);
      pos_valid = tbl[i].pv; setPos(tbl[i].p0, tbl[i].p1);
      step();
      checkVal($sformatf("tbl%0d.err_valid", i), int'(err_valid), int'(tbl[i].xEv));
      checkVal($sformatf("tbl%0d.error0", i), int'($signed(error[0 +: EW])), tbl[i].xErr0);
      checkVal($sformatf("tbl%0d.cmd_err", i), int'(cmd_err), int'(tbl[i].xCe));
    end
    checkVal("tbl.errorabs0", int'(errorabs[0 +: POS_W]), 20);
    checkVal("tbl.errorsign0", int'(errorsign[0]), 1);

    // Settle: target 174, position held at 173.
    cmd_valid = 1; cmd_ch = 0; cmd_target = POS_W'(174);
    step();
    cmd_valid = 0;
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      if (cmd_ready) begin seen = 1; break; end
      step();
    end
    checkVal("rampDone", int'(seen), 1);
    step();
    pos_valid = 1; setPos(173, 0);
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (in_pos[0]) begin n = k; break; end
    end
    checkVal("settleEdges", n, 5);
    cmd_valid = 1; cmd_ch = 3'd5; cmd_target = '0;
    step();
    checkVal("badCh.cmd_err", int'(cmd_err), 1);
    checkVal("badCh.in_pos0", int'(in_pos[0]), 1);
    cmd_valid = 0;
    step();
    checkVal("badCh.cmd_errEnd", int'(cmd_err), 0);
    checkVal("badCh.in_posHeld", int'(in_pos[0]), 1);
    setPos(170, 0);
    step();
    checkVal("drift.in_posPipe", int'(in_pos[0]), 1);
    pos_valid = 0;
    step();
    checkVal("drift.in_posDrop", int'(in_pos[0]), 0);

    // Asynchronous reset in the middle of a ramp.
    cmd_valid = 1; cmd_ch = 0; cmd_target = POS_W'(400);
    step();
    cmd_valid = 0;
    step();
    #3 reset = 1'b1;
    #1;
    checkVal("asyncRst.cmd_ready", int'(cmd_ready), 1);
    checkVal("asyncRst.err_valid", int'(err_valid), 0);
    checkVal("asyncRst.error", int'(error != '0), 0);
    checkVal("asyncRst.errorabs", int'(errorabs != '0), 0);
    checkVal("asyncRst.in_pos", int'(in_pos), 0);
    checkVal("asyncRst.cmd_err", int'(cmd_err), 0);
    modelReset();
    step();
    reset = 1'b0;
    step();

`ifdef POS_ERR_SLEW_LIMIT_EN
    // Ramp to 10 observed through error with position fixed at 0.
    cmd_valid = 1; cmd_ch = 0; cmd_target = POS_W'(10);
    pos_valid = 1; setPos(0, 0);
    step();
    cmd_valid = 0;
    checkVal("ramp.readyLow", int'(cmd_ready), 0);
    lastErr = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      cur = int'($signed(error[0 +: EW]));
      if (cur != lastErr) begin seq.push_back(cur); lastErr = cur; end
    end
    checkVal("ramp.steps", seq.size(), 3);
    if (seq.size() == 3) begin
      checkVal("ramp.sp1", seq[0], 4);
      checkVal("ramp.sp2", seq[1], 8);
      checkVal("ramp.sp3", seq[2], 10);
    end
    pos_valid = 0;
    step();
`endif

    // Randomized traffic checked against the model.
    for (int k = 0; k < 600; k++) begin
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_ch     = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      cmd_target = ($urandom_range(0, 9) == 0) ? POS_W'($urandom_range(0, 4095))
                                               : POS_W'($urandom_range(0, 60));
      pv         = ($urandom_range(0, 3) != 0) ? 1 : 0;
      pos_valid  = pv[0];
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 7) == 0) base = int'($urandom_range(0, 4095));
        else begin
          base = mSp[c] + int'($urandom_range(0, 6)) - 3;
          if (base < 0) base = 0;
          if (base > 4095) base = 4095;
        end
        pos[c*POS_W +: POS_W] = POS_W'(base);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
